// File: rtl/adpor_seq.sv
// adpor_seq: all-digital power-on-reset sequencer with brown-out detect and staggered domain release
// Ports: clk, rst_n (async active-low), sw_rst_req (sync re-sequence request),
//        rst_n_out[NUM_DOMAINS] (active-low domain resets, bit 0 first), sig_ok, por_event, busy
module adpor_seq #(
  parameter int LENGTH      = 16,
  parameter int NUM_CHAINS  = 4,
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_GAP   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_rst_req,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   sig_ok,
  output logic                   por_event,
  output logic                   busy
);
  localparam int MAXC = HOLD_CYCLES > STAGE_GAP ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int IW   = $clog2(NUM_DOMAINS + 1);
  typedef enum logic [2:0] {WAIT_SIG = 3'd0, HOLD = 3'd1, RELEASE = 3'd2, RUN = 3'd3} state_e;
  state_e                            state_q;
  logic   [CW-1:0]                   cnt_q;
  logic   [IW-1:0]                   idx_q;
  logic   [NUM_CHAINS-1:0][LENGTH-1:0] chain_q;
  // Chains are deliberately un-reset: their contents after power loss are what reveal the brown-out.
  always_ff @(posedge clk)
    for (int c = 0; c < NUM_CHAINS; c++) chain_q[c] <= {c % 2 == 0, chain_q[c][LENGTH-1:1]};
  always_comb begin
    sig_ok = 1'b1;
    for (int c = 0; c < NUM_CHAINS; c++)
      if (chain_q[c] != (c % 2 == 0 ? {LENGTH{1'b1}} : {LENGTH{1'b0}})) sig_ok = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= WAIT_SIG;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_n_out <= '0;
      por_event <= 1'b0;
      busy      <= 1'b1;
    end else begin
      por_event <= 1'b0;
      case (state_q)
        WAIT_SIG: begin
          rst_n_out <= '0;
          busy      <= 1'b1;
          if (sig_ok) begin
            state_q <= HOLD;
            cnt_q   <= '0;
          end
        end
        HOLD, RELEASE, RUN:
          // A lost signature beats a software request so the brown-out is always flagged.
          if (!sig_ok || sw_rst_req) begin
            state_q   <= WAIT_SIG;
            rst_n_out <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            busy      <= 1'b1;
            por_event <= !sig_ok;
          end else if (state_q == HOLD) begin
            if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
              rst_n_out[0] <= 1'b1;
              idx_q        <= IW'(1);
              cnt_q        <= '0;
              state_q      <= NUM_DOMAINS == 1 ? RUN : RELEASE;
              busy         <= 1'(NUM_DOMAINS != 1);
            end else cnt_q <= cnt_q + CW'(1);
          end else if (state_q == RELEASE) begin
            if (cnt_q == CW'(STAGE_GAP - 1)) begin
              rst_n_out[idx_q] <= 1'b1;
              idx_q            <= idx_q + IW'(1);
              cnt_q            <= '0;
              if (idx_q == IW'(NUM_DOMAINS - 1)) begin
                state_q <= RUN;
                busy    <= 1'b0;
              end
            end else cnt_q <= cnt_q + CW'(1);
          end
        default: begin
          state_q   <= WAIT_SIG;
          rst_n_out <= '0;
          cnt_q     <= '0;
          idx_q     <= '0;
          busy      <= 1'b1;
        end
      endcase
    end
endmodule
